// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with a valid/ready handshake on both sides.
//
// Single-cycle operations (AND, OR, ADD, SUB, XOR, SLT, SLTU, SRL, SLL, SRA)
// are registered one edge after acceptance. MUL, DIVU and REMU run
// iteratively, one bit per clock, for WIDTH clocks.
//
// Ports:
//   i_clk        clock, all state updates on the rising edge
//   i_rst        synchronous, active-low reset
//   i_in_valid   operands/opcode valid
//   o_in_ready   block can accept (high only in IDLE)
//   i_op1        first operand
//   i_op2        second operand / shift amount (low SHW bits)
//   i_alu_op     4-bit operation select
//   o_out_valid  result/zero valid, held until i_out_ready
//   i_out_ready  consumer accepts the result
//   o_result     registered result
//   o_zero       registered, 1 when result is zero
module alu_mc #(
  parameter int WIDTH = 32,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_op1,
  input  logic [WIDTH-1:0] i_op2,
  input  logic [3:0]       i_alu_op,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_zero
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_MUL  = 4'b0011;
  localparam logic [3:0] OP_SLT  = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLTU = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_DIVU = 4'b1011;
  localparam logic [3:0] OP_REMU = 4'b1100;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_stateNext;
  logic [3:0]       r_op;
  logic [SHW-1:0]   r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;

  logic             w_accept;
  logic             w_isIterIn;
  logic             w_lastStep;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_quick;
  logic [WIDTH-1:0] w_mulAcc;
  logic [WIDTH:0]   w_remShift;
  logic [WIDTH:0]   w_remDiff;
  logic             w_remGe;
  logic [WIDTH-1:0] w_remNext;
  logic [WIDTH-1:0] w_qNext;
  logic [WIDTH-1:0] w_iterResult;

  assign w_accept    = i_in_valid && (r_state == S_IDLE);
  assign w_isIterIn  = (i_alu_op == OP_MUL) || (i_alu_op == OP_DIVU) || (i_alu_op == OP_REMU);
  assign w_lastStep  = (r_cnt == SHW'(WIDTH - 1));
  assign w_shamt     = i_op2[SHW-1:0];

  assign o_in_ready  = (r_state == S_IDLE);
  assign o_out_valid = (r_state == S_DONE);
  assign o_result    = r_result;
  assign o_zero      = r_zero;

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state logic. The done state waits for the consumer; the iterative
  // state leaves after the WIDTH-th step.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_stateNext = w_isIterIn ? S_ITER : S_DONE;
        end
      end
      S_ITER: begin
        if (w_lastStep) begin
          w_stateNext = S_DONE;
        end
      end
      S_DONE: begin
        if (i_out_ready) begin
          w_stateNext = S_IDLE;
        end
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

  // Single-cycle result, computed straight from the input operands so it can
  // be registered on the accepting edge. Unknown opcodes produce zero.
  always_comb begin
    w_quick = '0;
    case (i_alu_op)
      OP_AND:  w_quick = i_op1 & i_op2;
      OP_OR:   w_quick = i_op1 | i_op2;
      OP_ADD:  w_quick = i_op1 + i_op2;
      OP_SUB:  w_quick = i_op1 - i_op2;
      OP_XOR:  w_quick = i_op1 ^ i_op2;
      OP_SLT:  w_quick = {{(WIDTH-1){1'b0}}, ($signed(i_op1) < $signed(i_op2))};
      OP_SLTU: w_quick = {{(WIDTH-1){1'b0}}, (i_op1 < i_op2)};
      OP_SRL:  w_quick = i_op1 >> w_shamt;
      OP_SLL:  w_quick = i_op1 << w_shamt;
      OP_SRA:  w_quick = $signed(i_op1) >>> w_shamt;
      default: w_quick = '0;
    endcase
  end

  // One iteration step. For MUL, r_a is the left-shifting multiplicand and
  // r_b the right-shifting multiplier. For DIVU/REMU, r_q starts as the
  // dividend and fills with quotient bits from the bottom while r_acc holds
  // the partial remainder. The sign bit of the WIDTH+1 difference is the
  // borrow, so it doubles as the "remainder >= divisor" test. A zero
  // divisor always passes that test, which gives an all-ones quotient and
  // leaves the dividend as the remainder without special casing.
  always_comb begin
    w_mulAcc   = r_acc + (r_b[0] ? r_a : '0);
    w_remShift = {r_acc, r_q[WIDTH-1]};
    w_remDiff  = w_remShift - {1'b0, r_b};
    w_remGe    = !w_remDiff[WIDTH];
    w_remNext  = w_remGe ? w_remDiff[WIDTH-1:0] : w_remShift[WIDTH-1:0];
    w_qNext    = {r_q[WIDTH-2:0], w_remGe};
    case (r_op)
      OP_MUL:  w_iterResult = w_mulAcc;
      OP_DIVU: w_iterResult = w_qNext;
      default: w_iterResult = w_remNext;
    endcase
  end

  // Datapath registers: operand capture at acceptance, the iteration step
  // while in ITER, and the result/zero registers that stay put through DONE.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_op     <= '0;
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_q      <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op  <= i_alu_op;
            r_cnt <= '0;
            if (w_isIterIn) begin
              r_a   <= i_op1;
              r_b   <= i_op2;
              r_q   <= i_op1;
              r_acc <= '0;
            end else begin
              r_result <= w_quick;
              r_zero   <= (w_quick == '0);
            end
          end
        end
        S_ITER: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_op == OP_MUL) begin
            r_acc <= w_mulAcc;
            r_a   <= r_a << 1;
            r_b   <= r_b >> 1;
          end else begin
            r_acc <= w_remNext;
            r_q   <= w_qNext;
          end
          if (w_lastStep) begin
            r_result <= w_iterResult;
            r_zero   <= (w_iterResult == '0);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: self-checking bench for alu_mc at WIDTH = 32.
//
// A table of directed vectors covers every opcode class, followed by
// hand-written sequences for reset, backpressure and reset during an
// iterative operation. Inputs are driven and outputs sampled on the falling
// edge. Latency is the number of rising edges after the accepting edge
// before out_valid is seen: 0 for single-cycle ops, 32 for iterative ops.
module tb_alu_mc;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic             inValid;
  logic             inReady;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic [3:0]       aluOp;
  logic             outValid;
  logic             outReady;
  logic [WIDTH-1:0] result;
  logic             zero;

  int passCount  = 0;
  int checkCount = 0;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  alu_mc #(.WIDTH(WIDTH)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_in_valid  (inValid),
    .o_in_ready  (inReady),
    .i_op1       (op1),
    .i_op2       (op2),
    .i_alu_op    (aluOp),
    .o_out_valid (outValid),
    .i_out_ready (outReady),
    .o_result    (result),
    .o_zero      (zero)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Issue one operation from IDLE with out_ready high, scramble the inputs
  // after acceptance, wait (bounded) for out_valid and return what was seen.
  // Leaves the DUT back in IDLE at a falling edge.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               output logic [31:0] res, output logic z, output int lat);
    outReady = 1'b1;
    aluOp    = op;
    op1      = a;
    op2      = b;
    inValid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    inValid = 1'b0;
    op1     = $urandom;
    op2     = $urandom;
    aluOp   = 4'($urandom);
    lat = 0;
    while (!outValid && lat < 200) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    res = result;
    z   = zero;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] gotRes;
    logic        gotZ;
    int          gotLat;

    vecs.push_back('{"ADD wrap",     4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 0});
    vecs.push_back('{"SRA",          4'b1010, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1'b0, 0});
    vecs.push_back('{"SLT",          4'b0100, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 0});
    vecs.push_back('{"SLTU",         4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 0});
    vecs.push_back('{"AND",          4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 0});
    vecs.push_back('{"OR",           4'b0001, 32'hF000_0001, 32'h0000_0F00, 32'hF000_0F01, 1'b0, 0});
    vecs.push_back('{"XOR",          4'b0101, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0, 0});
    vecs.push_back('{"SUB neg",      4'b0110, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0, 0});
    vecs.push_back('{"SRL",          4'b1000, 32'h8000_0000, 32'hFFFF_FFE1, 32'h4000_0000, 1'b0, 0});
    vecs.push_back('{"SLL 31",       4'b1001, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b0, 0});
    vecs.push_back('{"bad opcode",   4'b1101, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 1'b1, 0});
    vecs.push_back('{"MUL",          4'b0011, 32'h0001_0003, 32'h0000_0005, 32'h0005_000F, 1'b0, 32});
    vecs.push_back('{"MUL wrap",     4'b0011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32});
    vecs.push_back('{"DIVU 100/7",   4'b1011, 32'd100,       32'd7,         32'd14,        1'b0, 32});
    vecs.push_back('{"REMU 100/7",   4'b1100, 32'd100,       32'd7,         32'd2,         1'b0, 32});
    vecs.push_back('{"DIVU 5/0",     4'b1011, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b0, 32});
    vecs.push_back('{"REMU 5/0",     4'b1100, 32'd5,         32'd0,         32'd5,         1'b0, 32});
    vecs.push_back('{"DIVU big",     4'b1011, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, 1'b0, 32});
    vecs.push_back('{"REMU big",     4'b1100, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 1'b0, 32});
    vecs.push_back('{"REMU exact",   4'b1100, 32'd42,        32'd6,         32'd0,         1'b1, 32});

    // Reset held for two edges with a valid request pending.
    rst      = 1'b0;
    inValid  = 1'b1;
    aluOp    = 4'b0010;
    op1      = 32'd1;
    op2      = 32'd1;
    outReady = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset out_valid", 64'(outValid), 64'd0);
    checkOutput("reset result",    64'(result),   64'd0);
    checkOutput("reset zero",      64'(zero),     64'd0);
    checkOutput("reset in_ready",  64'(inReady),  64'd1);
    rst     = 1'b1;
    inValid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("post-reset out_valid", 64'(outValid), 64'd0);
    checkOutput("post-reset in_ready",  64'(inReady),  64'd1);

    // Table-driven vectors.
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, gotRes, gotZ, gotLat);
      checkOutput({vecs[i].name, " result"},  64'(gotRes), 64'(vecs[i].res));
      checkOutput({vecs[i].name, " zero"},    64'(gotZ),   64'(vecs[i].z));
      checkOutput({vecs[i].name, " latency"}, 64'(gotLat), 64'(vecs[i].lat));
      checkOutput({vecs[i].name, " idle"},    64'(inReady), 64'd1);
    end

    // Backpressure: hold DONE for 10 cycles while a second request waits.
    outReady = 1'b0;
    aluOp    = 4'b0010;
    op1      = 32'd7;
    op2      = 32'd8;
    inValid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    aluOp = 4'b0110;
    op1   = 32'd9;
    op2   = 32'd1;
    checkOutput("bp enter out_valid", 64'(outValid), 64'd1);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("bp out_valid", 64'(outValid), 64'd1);
      checkOutput("bp result",    64'(result),   64'd15);
      checkOutput("bp zero",      64'(zero),     64'd0);
      checkOutput("bp in_ready",  64'(inReady),  64'd0);
    end
    outReady = 1'b1;
    aluOp    = 4'b0010;
    op1      = 32'd2;
    op2      = 32'd2;
    @(posedge clk);
    @(negedge clk);
    checkOutput("bp release out_valid", 64'(outValid), 64'd0);
    checkOutput("bp release in_ready",  64'(inReady),  64'd1);
    @(posedge clk);
    @(negedge clk);
    inValid = 1'b0;
    checkOutput("bp next out_valid", 64'(outValid), 64'd1);
    checkOutput("bp next result",    64'(result),   64'd4);
    @(posedge clk);
    @(negedge clk);

    // Reset after ten DIVU steps aborts the operation.
    aluOp   = 4'b1011;
    op1     = 32'd100;
    op2     = 32'd7;
    inValid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    inValid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    checkOutput("mid-iter busy", 64'(inReady), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    checkOutput("abort out_valid", 64'(outValid), 64'd0);
    checkOutput("abort result",    64'(result),   64'd0);
    checkOutput("abort zero",      64'(zero),     64'd0);
    checkOutput("abort in_ready",  64'(inReady),  64'd1);
    repeat (40) @(posedge clk);
    @(negedge clk);
    checkOutput("abort no late valid", 64'(outValid), 64'd0);
    applyStimulus(4'b0010, 32'd2, 32'd3, gotRes, gotZ, gotLat);
    checkOutput("after abort ADD result",  64'(gotRes), 64'd5);
    checkOutput("after abort ADD zero",    64'(gotZ),   64'd0);
    checkOutput("after abort ADD latency", 64'(gotLat), 64'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU that replaces the single-cycle combinational ALU in the datapath. It executes all base operations with a one-cycle registered latency. It adds iterative unsigned multiply, divide and remainder, plus unsigned compare. Operand/result transfer uses a valid/ready handshake, so the control unit can stall on long operations.

## Interface
- WIDTH, 32, datapath width; power of two, 8..64
- SHW, $clog2(WIDTH), shift-amount width (derived, not overridden)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset; synchronous, active-low
- in_valid  in  1  operands/opcode valid
- in_ready  out  1  block can accept; high only in IDLE
- op1  in  WIDTH  first operand
- op2  in  WIDTH  second operand / shift amount (op2[SHW-1:0])
- alu_op  in  4  operation select
- out_valid  out  1  result/zero valid; held until out_ready
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  registered result
- zero  out  1  registered, 1 when result == 0

## Operation
- Opcodes, 1-cycle class: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0101 XOR, 0100 SLT (signed), 0111 SLTU (unsigned), 1000 SRL, 1001 SLL, 1010 SRA.
- Opcodes, iterative class (WIDTH cycles): 0011 MUL (low WIDTH bits of unsigned product), 1011 DIVU (quotient), 1100 REMU (remainder).
- Any other opcode: result = 0, zero = 1, 1-cycle class.
- ADD/SUB wrap modulo 2^WIDTH; no carry/overflow outputs.
- SLT/SLTU: result = {WIDTH-1 zeros, flag}.
- Shifts use only op2[SHW-1:0]; SRA replicates op1[WIDTH-1].
- Divide by zero: DIVU gives all ones; REMU gives op1. No exception.
- op1, op2 and alu_op are captured at acceptance; later input changes have no effect.
- MUL: shift-add, one multiplier bit per cycle, LSB first.
- DIVU/REMU: restoring division, one quotient bit per cycle, MSB first, with a WIDTH+1 partial remainder.
- Acceptance: in_valid & in_ready at a rising edge.
- State machine:
  - IDLE: in_ready = 1. On acceptance, a 1-cycle op computes result/zero into registers and goes to DONE; an iterative op loads operands, clears the counter and goes to ITER.
  - ITER: one step per edge, counter increments. On the WIDTH-th step, load result/zero and go to DONE.
  - DONE: out_valid = 1, result/zero stable. If out_ready, go to IDLE.
- in_ready = (state == IDLE). No acceptance in ITER or DONE; in_valid is ignored there.
- out_valid = (state == DONE).

## Timing
- Reset: while rst = 0 at a rising edge, the next state is IDLE, result = 0, zero = 0, out_valid = 0, counter = 0, and operand registers are cleared. in_ready = 1 from the first cycle after reset.
- Reset mid-operation (ITER or DONE) aborts it; no out_valid is produced for the aborted op.
- 1-cycle ops: accepted at edge k, out_valid = 1 from edge k+1.
- Iterative ops: accepted at edge k, steps at edges k+1..k+WIDTH, out_valid = 1 from edge k+WIDTH.
- DONE exit: out_ready high at edge m gives IDLE after m; earliest next acceptance at m+1. Peak throughput for 1-cycle ops is one op per 2 cycles.
- Backpressure: out_ready low holds DONE indefinitely with result/zero unchanged.
- out_ready outside DONE is ignored.
- Critical path: ADD/SUB/compare through the result register; one WIDTH+1 subtract per ITER step.

## Test plan
- Reset: hold rst = 0 for 2 cycles with in_valid = 1 -> out_valid = 0, result = 0, zero = 0, in_ready = 1; no operation accepted.
- 1-cycle ops, WIDTH=32, out_ready = 1:
  - ADD 0xFFFFFFFF+1 -> 0x00000000, zero = 1, one cycle after accept.
  - SRA 0x80000000 by op2 = 0x24 (amount 4) -> 0xF8000000.
  - SLT 0xFFFFFFFF vs 1 -> 1; SLTU with the same operands -> 0.
- MUL 0x0001_0003 × 0x0000_0005 -> 0x0005_000F, out_valid exactly 32 cycles after accept. Change op1 during ITER -> result unchanged.
- DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
- Backpressure: out_ready = 0 for 10 cycles in DONE -> out_valid, result and zero stable and in_ready = 0. Then raise out_ready -> IDLE next cycle, next op accepted the following edge.
- Reset mid-ITER: assert rst at ITER step 10 of DIVU -> IDLE with cleared outputs; a new ADD 2+3 then returns 5 normally.
